// File: rtl/gpio_in_ctrl_pkg.sv
// Shared definitions for the GPIO input controller: bus width,
// register indices and edge-select encodings.
package gpio_in_ctrl_pkg;

  localparam int BUS_W = 32;

  // Register map (word index on the addr port).
  localparam logic [1:0] GPIO_IN_ADDR_DATA    = 2'd0;
  localparam logic [1:0] GPIO_IN_ADDR_STATUS  = 2'd1;
  localparam logic [1:0] GPIO_IN_ADDR_MASK    = 2'd2;
  localparam logic [1:0] GPIO_IN_ADDR_EDGESEL = 2'd3;

  // Per-pin edge-select encodings held in EDGESEL.
  localparam logic EDGE_SEL_RISE = 1'b0;
  localparam logic EDGE_SEL_FALL = 1'b1;

endpackage : gpio_in_ctrl_pkg

// File: rtl/gpio_in_debounce.sv
// Single-pin input conditioner: two-flop synchronizer followed by a
// debounce counter that only accepts a level after it has been stable
// for DEBOUNCE_CYCLES consecutive cycles.
module gpio_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic pinIn,
  output logic pinOut
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs; blocking here would collapse sync1/sync2
    // into a single stage.
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pinIn;
      sync2 <= sync2 == sync1 ? sync2 : sync1;
    end
  end

  // Count consecutive cycles where the synced level differs from the
  // accepted level; accept it once the count reaches CNT_LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      pinOut <= 1'b0;
    end else if (sync2 == pinOut) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      pinOut <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : gpio_in_debounce

// File: rtl/gpio_in_ctrl.sv
// GPIO input controller: per-pin synchronize/debounce, edge detection into
// a sticky write-1-to-clear STATUS register, maskable level interrupt, and a
// simple bus slave exposing DATA, STATUS, MASK and EDGESEL.
module gpio_in_ctrl
  import gpio_in_ctrl_pkg::*;
#(
  parameter int PIN_NUM         = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIN_NUM-1:0] GPIOIn,
  input  logic               cs,
  input  logic               as,
  input  logic               rw,
  input  logic [1:0]         addr,
  input  logic [BUS_W-1:0]   wrData,
  output logic [BUS_W-1:0]   rdData,
  output logic               rdy,
  output logic               irq
);

  logic [PIN_NUM-1:0] db;
  logic [PIN_NUM-1:0] db_prev;
  logic [PIN_NUM-1:0] rise;
  logic [PIN_NUM-1:0] fall;
  logic [PIN_NUM-1:0] edge_evt;
  logic [PIN_NUM-1:0] status;
  logic [PIN_NUM-1:0] mask;
  logic [PIN_NUM-1:0] edge_sel;
  logic [PIN_NUM-1:0] wr_pins;
  logic [BUS_W-1:0]   reg_val;
  logic               accept;
  logic               wr_en;

  assign accept  = cs & as;
  assign wr_en   = accept & ~rw;
  assign wr_pins = wrData[PIN_NUM-1:0];

  // Write-data bits above the implemented pins are deliberately ignored.
  if (PIN_NUM < BUS_W) begin : g_wr_upper
    logic unused_wr_upper;
    assign unused_wr_upper = ^wrData[BUS_W-1:PIN_NUM];
  end

  // One synchronizer + debouncer per pin.
  for (genvar i = 0; i < PIN_NUM; i++) begin : g_pin
    gpio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .pinIn (GPIOIn[i]),
      .pinOut(db[i])
    );
  end

  // Remember last cycle's debounced value for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: every register, including the whole control/status set, gets a
    // synchronous reset branch; there is no storage array to leave unreset.
    if (reset) db_prev <= '0;
    else       db_prev <= db;
  end

  assign rise = db & ~db_prev;
  assign fall = ~db & db_prev;

  // Select the edge polarity each pin reports, as configured in EDGESEL.
  always_comb begin
    // NOTE: the output is given a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    edge_evt = '0;
    for (int i = 0; i < PIN_NUM; i++) begin
      edge_evt[i] = (edge_sel[i] == EDGE_SEL_FALL) ? fall[i] : rise[i];
    end
  end

  // Sticky edge flags: W1C clears, but a same-cycle edge keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      status <= '0;
    end else if (wr_en && addr == GPIO_IN_ADDR_STATUS) begin
      status <= (status & ~wr_pins) | edge_evt;
    end else begin
      status <= status | edge_evt;
    end
  end

  // Software-writable interrupt mask and edge-select configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask     <= '0;
      edge_sel <= '0;
    end else if (wr_en) begin
      if (addr == GPIO_IN_ADDR_MASK)    mask     <= wr_pins;
      if (addr == GPIO_IN_ADDR_EDGESEL) edge_sel <= wr_pins;
    end
  end

  // Registered level interrupt from enabled status flags.
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(status & mask);
  end

  // Read multiplexer; unimplemented upper bits read as zero.
  always_comb begin
    reg_val = '0;
    case (addr)
      GPIO_IN_ADDR_DATA:    reg_val[PIN_NUM-1:0] = db;
      GPIO_IN_ADDR_STATUS:  reg_val[PIN_NUM-1:0] = status;
      GPIO_IN_ADDR_MASK:    reg_val[PIN_NUM-1:0] = mask;
      GPIO_IN_ADDR_EDGESEL: reg_val[PIN_NUM-1:0] = edge_sel;
      default:              reg_val = '0;
    endcase
  end

  // Single-cycle bus response: rdy and read data one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy    <= 1'b0;
      rdData <= '0;
    end else begin
      rdy    <= accept;
      rdData <= (accept && rw) ? reg_val : '0;
    end
  end

endmodule : gpio_in_ctrl
